ramb16_s9_s36_pack_fifo: RTL and testbench

//  Single-clock byte-to-word packing FIFO over a 2048x9 (512x36) block RAM.

---
 rtl/ramb16_s9_s36_pack_fifo.sv | 149 ++++++++++++++
 tb/tb_ramb16_s9_s36_pack_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ramb16_s9_s36_pack_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ramb16_s9_s36_pack_fifo
//  Description : Single-clock byte-to-word packing FIFO over a 2048x9
//                (512x36) block RAM. 9-bit bytes are pushed on the write
//                side and 36-bit words are popped on the read side. WLAST
//                pads the rest of the current word with PAD_VALUE.
//  Revision    : 1.0 - initial release
// ============================================================================
module ramb16_s9_s36_pack_fifo #(
    parameter logic [8:0]  PAD_VALUE = 9'h000,
    parameter logic [35:0] SRVAL     = 36'h0,
    parameter logic [11:0] AFULL_LVL = 12'd2040
) (
    input  logic        CLK,
    input  logic        SSR,
    input  logic        WE,
    input  logic [7:0]  DI,
    input  logic        DIP,
    input  logic        WLAST,
    output logic        FULL,
    output logic        ALMOST_FULL,
    output logic        OVERFLOW,
    output logic        VALID,
    input  logic        RE,
    output logic [31:0] DO,
    output logic [3:0]  DOP,
    output logic [11:0] BYTE_COUNT
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PAD  = 1'b1
    } state_t;

    localparam logic [11:0] c_RAM_BYTES = 12'd2048;

    state_t      r_state;
    logic [11:0] r_wr_ptr;      // byte pointer, bit 11 is the wrap bit
    logic [9:0]  r_wr_word_d;   // word part of r_wr_ptr, one cycle late
    logic [9:0]  r_rd_ptr;      // word pointer, bit 9 is the wrap bit
    logic        r_valid;
    logic        r_overflow;

    logic [11:0] w_byte_count;
    logic        w_ram_full;
    logic        w_full;
    logic        w_accept;
    logic        w_pad_wr;
    logic        w_wr_en;
    logic [8:0]  w_wdata;
    logic        w_words_avail;
    logic        w_fire;

    // Occupancy, flow control and write-port selection
    always_comb begin
        w_byte_count  = r_wr_ptr - {r_rd_ptr, 2'b00};
        w_ram_full    = (w_byte_count == c_RAM_BYTES);
        w_full        = w_ram_full | (r_state == ST_PAD);
        w_accept      = WE & ~w_full;
        // Pad bytes stall while the RAM is full, just like user bytes would
        w_pad_wr      = (r_state == ST_PAD) & ~w_ram_full;
        w_wr_en       = w_accept | w_pad_wr;
        w_wdata       = (r_state == ST_PAD) ? PAD_VALUE : {DIP, DI};
        // The delayed write pointer keeps a word from being fetched on the
        // same edge its last byte is written, so reads only see whole words
        w_words_avail = (r_wr_word_d != r_rd_ptr);
        w_fire        = w_words_avail & (~r_valid | RE);
    end

    // Write pointer, pad FSM and overflow pulse
    always_ff @(posedge CLK) begin
        if (SSR) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= 12'd0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= WE & w_full;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 12'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && WLAST && (r_wr_ptr[1:0] != 2'd3)) begin
                        r_state <= ST_PAD;
                    end
                end
                ST_PAD: begin
                    if (w_pad_wr && (r_wr_ptr[1:0] == 2'd3)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Read pointer, fetch scheduling and output-valid tracking
    always_ff @(posedge CLK) begin
        if (SSR) begin
            r_wr_word_d <= 10'd0;
            r_rd_ptr    <= 10'd0;
            r_valid     <= 1'b0;
        end else begin
            r_wr_word_d <= r_wr_ptr[11:2];
            if (w_fire) begin
                r_rd_ptr <= r_rd_ptr + 10'd1;
                r_valid  <= 1'b1;
            end else if (RE) begin
                r_valid  <= 1'b0;
            end
        end
    end

    // One 512x9 bank per byte lane; the output register doubles as DO/DOP
    for (genvar k = 0; k < 4; k++) begin : g_lane
        localparam logic [1:0] c_LANE = 2'(k);

        logic [8:0] r_mem [0:511];
        logic [8:0] r_q;

        // Byte write into this lane's bank
        always_ff @(posedge CLK) begin
            if (w_wr_en && (r_wr_ptr[1:0] == c_LANE)) begin
                r_mem[r_wr_ptr[10:2]] <= w_wdata;
            end
        end

        // Registered word read, held until the next fetch
        always_ff @(posedge CLK) begin
            if (SSR) begin
                r_q <= {SRVAL[32+k], SRVAL[8*k +: 8]};
            end else if (w_fire) begin
                r_q <= r_mem[r_rd_ptr[8:0]];
            end
        end

        assign DO[8*k +: 8] = r_q[7:0];
        assign DOP[k]       = r_q[8];
    end

    assign FULL        = w_full;
    assign ALMOST_FULL = (w_byte_count >= AFULL_LVL);
    assign OVERFLOW    = r_overflow;
    assign VALID       = r_valid;
    assign BYTE_COUNT  = w_byte_count;

endmodule
`default_nettype wire

// File: tb/tb_ramb16_s9_s36_pack_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ramb16_s9_s36_pack_fifo
//  Description : Self-checking bench for ramb16_s9_s36_pack_fifo. A byte-level
//                model tracks absolute byte/word counts and stored bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ramb16_s9_s36_pack_fifo;

    localparam logic [8:0]  c_PAD   = 9'h000;
    localparam logic [35:0] c_SRVAL = 36'h0;

    logic        clk = 1'b0;
    logic        ssr, we, dip, wlast, re;
    logic [7:0]  di;
    logic        full, almost_full, overflow, valid;
    logic [31:0] do_w;
    logic [3:0]  dop;
    logic [11:0] byte_count;

    int n_cmp = 0;
    int n_err = 0;
    int pops  = 0;

    // model state: absolute counts since the last reset
    int          m_wr;
    int          m_wr_prev;
    int          m_fetched;
    bit          m_pad;
    bit          m_valid;
    bit          m_ovf;
    logic [35:0] m_out;
    logic [8:0]  mem [int];

    ramb16_s9_s36_pack_fifo #(
        .PAD_VALUE (c_PAD),
        .SRVAL     (c_SRVAL),
        .AFULL_LVL (12'd2040)
    ) dut (
        .CLK         (clk),
        .SSR         (ssr),
        .WE          (we),
        .DI          (di),
        .DIP         (dip),
        .WLAST       (wlast),
        .FULL        (full),
        .ALMOST_FULL (almost_full),
        .OVERFLOW    (overflow),
        .VALID       (valid),
        .RE          (re),
        .DO          (do_w),
        .DOP         (dop),
        .BYTE_COUNT  (byte_count)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic model_update(bit s, bit w, logic [8:0] b, bit wl, bit r);
        int cnt;
        bit mfull;
        bit fire;
        int wn;
        bit padn;
        if (s) begin
            m_wr = 0; m_wr_prev = 0; m_fetched = 0; m_pad = 0;
            m_valid = 0; m_ovf = 0; m_out = c_SRVAL;
            mem.delete();
            return;
        end
        cnt   = m_wr - 4 * m_fetched;
        mfull = m_pad || (cnt == 2048);
        m_ovf = w && mfull;
        wn    = m_wr;
        padn  = m_pad;
        if (m_pad) begin
            if (cnt != 2048) begin
                mem[m_wr] = c_PAD;
                wn++;
                if (m_wr % 4 == 3) padn = 0;
            end
        end else if (w && !mfull) begin
            mem[m_wr] = b;
            wn++;
            if (wl && (m_wr % 4 != 3)) padn = 1;
        end
        // a word becomes fetchable one cycle after its last byte lands
        fire = (m_wr_prev / 4 > m_fetched) && (!m_valid || r);
        if (fire) begin
            for (int k = 0; k < 4; k++) begin
                m_out[8*k +: 8] = mem[4*m_fetched + k][7:0];
                m_out[32 + k]   = mem[4*m_fetched + k][8];
            end
            m_fetched++;
            m_valid = 1;
        end else if (r) begin
            m_valid = 0;
        end
        m_wr_prev = m_wr;
        m_wr      = wn;
        m_pad     = padn;
    endtask

    task automatic compare_all();
        int cnt;
        cnt = m_wr - 4 * m_fetched;
        check("valid",       64'(valid),       64'(m_valid));
        check("full",        64'(full),        64'(m_pad || cnt == 2048));
        check("almost_full", 64'(almost_full), 64'(cnt >= 2040));
        check("overflow",    64'(overflow),    64'(m_ovf));
        check("byte_count",  64'(byte_count),  64'(cnt));
        check("dop_do",      64'({dop, do_w}), 64'(m_out));
    endtask

    // one clock: drive inputs, advance the model at the edge, compare later
    task automatic step(bit s, bit w, logic [7:0] d, bit p, bit wl, bit r);
        ssr = s; we = w; di = d; dip = p; wlast = wl; re = r;
        #1;
        if (!s && valid && r) pops++;
        @(posedge clk);
        model_update(s, w, {p, d}, wl, r);
        @(negedge clk);
        compare_all();
    endtask

    task automatic push(logic [7:0] d, bit p, bit wl, bit r);
        step(1'b0, 1'b1, d, p, wl, r);
    endtask

    task automatic idle(bit r);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, r);
    endtask

    task automatic wait_word(string name, logic [35:0] exp);
        for (int i = 0; i < 10 && !valid; i++) idle(1'b0);
        check({name, "_valid"}, 64'(valid), 64'd1);
        check({name, "_word"},  64'({dop, do_w}), 64'(exp));
        idle(1'b1);
    endtask

    initial begin
        ssr = 1'b1; we = 1'b0; di = 8'h00; dip = 1'b0; wlast = 1'b0; re = 1'b0;
        @(negedge clk);

        // reset
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_out",   64'({dop, do_w}), 64'(c_SRVAL));
        check("rst_full",  64'(full), 64'd0);
        check("rst_count", 64'(byte_count), 64'd0);
        check("rst_ovf",   64'(overflow), 64'd0);

        // pack four bytes: valid two edges after the fourth byte
        push(8'h11, 1'b1, 1'b0, 1'b1);
        push(8'h22, 1'b0, 1'b0, 1'b1);
        push(8'h33, 1'b1, 1'b0, 1'b1);
        push(8'h44, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        check("pack_early", 64'(valid), 64'd0);
        idle(1'b1);
        check("pack_valid", 64'(valid), 64'd1);
        check("pack_word",  64'({dop, do_w}), 64'({4'b0101, 32'h44332211}));
        idle(1'b1);
        check("pack_popped", 64'(valid), 64'd0);

        // WLAST on lane 0 pads three bytes
        push(8'hAA, 1'b1, 1'b1, 1'b1);
        check("pad_full1", 64'(full), 64'd1);
        idle(1'b1);
        check("pad_full2", 64'(full), 64'd1);
        idle(1'b1);
        check("pad_full3", 64'(full), 64'd1);
        idle(1'b1);
        check("pad_done", 64'(full), 64'd0);
        wait_word("pad", {4'b0001, 32'h000000AA});
        push(8'h5A, 1'b0, 1'b0, 1'b1);
        push(8'h01, 1'b0, 1'b0, 1'b1);
        push(8'h02, 1'b0, 1'b0, 1'b1);
        push(8'h03, 1'b0, 1'b0, 1'b1);
        wait_word("post_pad", {4'b0000, 32'h0302015A});

        // fill to capacity with the consumer stalled
        for (int i = 0; i < 8; i++) idle(1'b1);
        check("fill_start", 64'(byte_count), 64'd0);
        for (int i = 0; i < 2052; i++) push(8'(i), ^8'(i), 1'b0, 1'b0);
        check("fill_full",  64'(full), 64'd1);
        check("fill_count", 64'(byte_count), 64'd2048);
        check("fill_valid", 64'(valid), 64'd1);
        push(8'hEE, 1'b1, 1'b0, 1'b0);
        check("fill_ovf",   64'(overflow), 64'd1);
        check("fill_hold",  64'(byte_count), 64'd2048);
        idle(1'b0);
        check("fill_ovf_end", 64'(overflow), 64'd0);
        idle(1'b1);
        check("pop_full",  64'(full), 64'd0);
        check("pop_count", 64'(byte_count), 64'd2044);

        // streaming across the pointer wrap
        for (int i = 0; i < 700 && (valid || byte_count != 12'd0); i++) idle(1'b1);
        check("drain_count", 64'(byte_count), 64'd0);
        pops = 0;
        for (int i = 0; i < 6000; i++) push(8'(i + 1), ^8'(i + 1), 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) idle(1'b1);
        check("stream_words", 64'(pops), 64'd1500);

        // reset during the second pad cycle
        push(8'hC3, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("midpad_full",  64'(full), 64'd0);
        check("midpad_valid", 64'(valid), 64'd0);
        check("midpad_count", 64'(byte_count), 64'd0);
        push(8'hD1, 1'b1, 1'b0, 1'b0);
        push(8'hD2, 1'b1, 1'b0, 1'b0);
        push(8'hD3, 1'b0, 1'b0, 1'b0);
        push(8'hD4, 1'b0, 1'b0, 1'b0);
        wait_word("midpad_word", {4'b0011, 32'hD4D3D2D1});

        // random traffic: slow consumer first (reaches full and pad stalls)
        for (int i = 0; i < 4000; i++) begin
            step(1'b0, ($urandom % 4) != 0, 8'($urandom), 1'($urandom),
                 ($urandom % 16) == 0, ($urandom % 32) == 0);
        end
        for (int i = 0; i < 2500; i++) begin
            step(($urandom % 600) == 0, ($urandom % 4) != 0, 8'($urandom),
                 1'($urandom), ($urandom % 8) == 0, ($urandom % 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
